upsample_seq_ctrl: RTL



---
 rtl/upsample_seq_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/upsample_seq_ctrl.sv
// Single-job up-sampling sequencer: start -> clear UPSTR -> launch -> run -> post status to UPENDR; launch 2 cycles after start.
// Each CRF write holds addr/data and retries every cycle while crf_ac_wbusy is high; the FSM waits on acceptance.
module upsample_seq_ctrl #(
  parameter int unsigned CRF_DATA_WIDTH = 32,
  parameter int unsigned CRF_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_rstn,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSTR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPENDR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSRCAR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPDSTAR,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  output logic                      ac_up_start,
  output logic                      ac_up_abort,
  output logic [CRF_DATA_WIDTH-1:0] ac_up_srcaddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_up_dstaddr,
  input  logic                      up_ac_done,
  output logic                      ac_busy,
  output logic [CNT_WIDTH-1:0]      ac_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLR_START = 3'd1,
    S_LAUNCH    = 3'd2,
    S_RUN       = 3'd3,
    S_CLR_ABORT = 3'd4,
    S_WR_END    = 3'd5
  } state_e;

  localparam logic [CRF_ADDR_WIDTH-1:0] ADDR_UPSTR  = CRF_ADDR_WIDTH'(0);
  localparam logic [CRF_ADDR_WIDTH-1:0] ADDR_UPENDR = CRF_ADDR_WIDTH'(1);
  localparam logic [CRF_DATA_WIDTH-1:0] ST_DONE     = CRF_DATA_WIDTH'(3'b001);
  localparam logic [CRF_DATA_WIDTH-1:0] ST_TIMEOUT  = CRF_DATA_WIDTH'(3'b011);
  localparam logic [CRF_DATA_WIDTH-1:0] ST_ABORT    = CRF_DATA_WIDTH'(3'b101);
  localparam bit                        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0]      RUN_LAST    =
    TIMEOUT_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_e                    state_q, state_d;
  logic [CRF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [CRF_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CRF_DATA_WIDTH-1:0] src_q, src_d;
  logic [CRF_DATA_WIDTH-1:0] dst_q, dst_d;
  logic [CRF_DATA_WIDTH-1:0] status_q, status_d;
  logic [CNT_WIDTH-1:0]      run_cnt_q, run_cnt_d;
  logic [CNT_WIDTH-1:0]      frame_cnt_q, frame_cnt_d;
  logic                      abort_q, abort_d;

  logic wr_pending;
  logic wr_accept;
  logic start_req;
  logic abort_req;
  logic timeout_hit;
  logic unused_inputs;

  assign wr_pending  = (state_q == S_CLR_START) || (state_q == S_CLR_ABORT) ||
                       (state_q == S_WR_END);
  assign wr_accept   = wr_pending && !crf_ac_wbusy;
  assign start_req   = crf_ac_UPSTR[0];
  assign abort_req   = crf_ac_UPSTR[1];
  assign timeout_hit = TIMEOUT_EN && (run_cnt_q == RUN_LAST);

  // UPENDR is monitor-only and UPSTR carries only start/abort bits.
  assign unused_inputs = ^{crf_ac_UPENDR, crf_ac_UPSTR[CRF_DATA_WIDTH-1:2]};

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_rstn) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      wdata_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      status_q    <= '0;
      run_cnt_q   <= '0;
      frame_cnt_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      status_q    <= status_d;
      run_cnt_q   <= run_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      abort_q     <= abort_d;
    end
  end

  // Completion outranks abort, which outranks timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) state_d = S_CLR_START;
      end
      S_CLR_START: begin
        if (wr_accept) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (up_ac_done)       state_d = S_WR_END;
        else if (abort_req)   state_d = S_CLR_ABORT;
        else if (timeout_hit) state_d = S_WR_END;
      end
      S_CLR_ABORT: begin
        if (wr_accept) state_d = S_WR_END;
      end
      S_WR_END: begin
        if (wr_accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    src_d       = src_q;
    dst_d       = dst_q;
    status_d    = status_q;
    run_cnt_d   = run_cnt_q;
    frame_cnt_d = frame_cnt_q;
    abort_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          src_d   = crf_ac_UPSRCAR;
          dst_d   = crf_ac_UPDSTAR;
          waddr_d = ADDR_UPSTR;
          wdata_d = '0;
        end
      end
      S_LAUNCH: begin
        run_cnt_d = '0;
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
        if (up_ac_done) begin
          status_d = ST_DONE;
          waddr_d  = ADDR_UPENDR;
          wdata_d  = ST_DONE;
        end else if (abort_req) begin
          abort_d  = 1'b1;
          status_d = ST_ABORT;
          waddr_d  = ADDR_UPSTR;
          wdata_d  = '0;
        end else if (timeout_hit) begin
          abort_d  = 1'b1;
          status_d = ST_TIMEOUT;
          waddr_d  = ADDR_UPENDR;
          wdata_d  = ST_TIMEOUT;
        end
      end
      S_CLR_ABORT: begin
        if (wr_accept) begin
          waddr_d = ADDR_UPENDR;
          wdata_d = status_q;
        end
      end
      S_WR_END: begin
        if (wr_accept) frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    ac_crf_wrt    = wr_pending;
    ac_crf_waddr  = waddr_q;
    ac_crf_wdata  = wdata_q;
    ac_up_start   = (state_q == S_LAUNCH);
    ac_up_abort   = abort_q;
    ac_up_srcaddr = src_q;
    ac_up_dstaddr = dst_q;
    ac_busy       = (state_q != S_IDLE);
    ac_frame_cnt  = frame_cnt_q;
  end

endmodule
